// File: rtl/line_mem_pkg.sv
// Shared types and helpers for the line memory controller.
// Holds the FSM state enum, default line geometry and a word-extract helper.
package line_mem_pkg;

    localparam int DATA_W         = 32;
    localparam int LINE_BYTES     = 16;
    localparam int LINE_W         = LINE_BYTES * 8;
    localparam int WORDS_PER_LINE = LINE_W / DATA_W;
    localparam int BEAT_W         = $clog2(WORDS_PER_LINE);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD,
        RD_DRAIN,
        DONE
    } state_e;

    // Word 0 sits in the least significant bits of the line.
    function automatic logic [DATA_W-1:0] line_word(
        input logic [LINE_W-1:0] line,
        input logic [BEAT_W-1:0] idx
    );
        return line[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/line_assembler.sv
// Word-to-line buffer: writes one word slot per cycle, clearable.
// Ports: clk, rst, clr_i, we_i, idx_i, word_i, line_o (registered), line_nxt_o (next value).
module line_assembler #(
    parameter int DW = 32,
    parameter int W  = 4,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [IW-1:0] idx_i,
    input  logic [DW-1:0] word_i,
    output logic [W*DW-1:0] line_o,
    output logic [W*DW-1:0] line_nxt_o
);

    logic [W*DW-1:0] line_q;

    always_comb begin
        line_nxt_o = line_q;
        if (we_i) begin
            line_nxt_o[idx_i*DW +: DW] = word_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_nxt_o;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/line_mem_ctrl.sv
// Line-granular refill/write-back controller serialising lines onto a word RAM.
// Ports: req_* (cache request), resp_* (refill result), crit_word_* (early word),
// busy, ram_* (single-port RAM, read data one cycle after ram_re).
// Optional macro LINE_MEM_CRIT_WORD_FIRST_EN: refill starts at crit_word.
module line_mem_ctrl
    import line_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_W,
    parameter int CACHE_LINE_SIZE = LINE_BYTES,
    parameter int LINE_ADDR_WIDTH = 4,
    localparam int W  = CACHE_LINE_SIZE * 8 / DATA_WIDTH,
    localparam int BW = $clog2(W),
    localparam int LW = CACHE_LINE_SIZE * 8,
    localparam int WORD_ADDR_WIDTH = LINE_ADDR_WIDTH + BW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_read,
    input  logic                       req_write,
    input  logic [LINE_ADDR_WIDTH-1:0] rd_line_addr,
    input  logic [LINE_ADDR_WIDTH-1:0] wr_line_addr,
    input  logic [LW-1:0]              wr_line_data,
    input  logic [BW-1:0]              crit_word,
    output logic                       resp_valid,
    output logic [LW-1:0]              resp_line_data,
    output logic                       crit_word_valid,
    output logic [DATA_WIDTH-1:0]      crit_word_data,
    output logic                       busy,
    output logic [WORD_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]      ram_wdata,
    output logic                       ram_we,
    output logic                       ram_re,
    input  logic [DATA_WIDTH-1:0]      ram_rdata
);

    state_e state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [BW-1:0] slot;
    logic [BW-1:0] rd_slot_q;
    logic          rd_pend_q;
    logic          rd_q, wr_q;
    logic [LINE_ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [LW-1:0] wr_data_q;
    logic [LW-1:0] resp_q;
    logic [LW-1:0] asm_line, asm_nxt;
    logic          accept;
    logic          last_beat;

    assign accept    = (state_q == IDLE) && req_valid;
    assign last_beat = (beat_q == BW'(W - 1));

`ifdef LINE_MEM_CRIT_WORD_FIRST_EN
    logic [BW-1:0] crit_q;

    // Refill order rotates so the critical word goes out first.
    assign slot = beat_q + crit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            crit_q <= '0;
        end else if (accept) begin
            crit_q <= crit_word;
        end
    end

    // The critical slot is read exactly once, on the first refill beat.
    assign crit_word_valid = rd_pend_q && (rd_slot_q == crit_q);
    assign crit_word_data  = crit_word_valid ? ram_rdata : '0;
`else
    logic unused_crit;

    assign unused_crit     = ^crit_word;
    assign slot            = beat_q;
    assign crit_word_valid = 1'b0;
    assign crit_word_data  = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic; the beat counter wraps naturally at W.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        state_d = WB;
                    end else if (req_read) begin
                        state_d = RD;
                    end
                end
            end
            WB: begin
                beat_d = beat_q + 1'b1;
                if (last_beat) begin
                    state_d = rd_q ? RD : DONE;
                end
            end
            RD: begin
                beat_d = beat_q + 1'b1;
                if (last_beat) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state_q)
            WB: begin
                ram_we    = 1'b1;
                ram_addr  = {wr_addr_q, beat_q};
                ram_wdata = line_word(wr_data_q, beat_q);
            end
            RD: begin
                ram_re   = 1'b1;
                ram_addr = {rd_addr_q, slot};
            end
            default: begin
            end
        endcase
    end

    assign req_ready      = (state_q == IDLE);
    assign busy           = ~req_ready;
    assign resp_valid     = (state_q == DONE);
    assign resp_line_data = resp_q;

    // Request latch and read-pipeline tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_pend_q <= 1'b0;
            rd_slot_q <= '0;
        end else begin
            if (accept) begin
                rd_q      <= req_read;
                wr_q      <= req_write;
                rd_addr_q <= rd_line_addr;
                wr_addr_q <= wr_line_addr;
                wr_data_q <= wr_line_data;
            end
            // Read data returns one cycle after issue; remember its slot.
            rd_pend_q <= (state_q == RD);
            rd_slot_q <= slot;
        end
    end

    // Response register loads the completed line including the final word.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= '0;
        end else if (state_q == RD_DRAIN) begin
            resp_q <= asm_nxt;
        end
    end

    logic unused_wr;
    assign unused_wr = wr_q ^ ^asm_line;

    line_assembler #(
        .DW (DATA_WIDTH),
        .W  (W)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept && req_read),
        .we_i       (rd_pend_q),
        .idx_i      (rd_slot_q),
        .word_i     (ram_rdata),
        .line_o     (asm_line),
        .line_nxt_o (asm_nxt)
    );

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Self-checking bench for line_mem_ctrl with a word RAM model.
// Table of line requests plus directed reset, drop and critical-word sequences.
module tb_line_mem_ctrl;

    localparam int NC = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_read, req_write;
    logic [3:0]   rd_line_addr, wr_line_addr;
    logic [127:0] wr_line_data;
    logic [1:0]   crit_word;
    logic         resp_valid;
    logic [127:0] resp_line_data;
    logic         crit_word_valid;
    logic [31:0]  crit_word_data;
    logic         busy;
    logic [5:0]   ram_addr;
    logic [31:0]  ram_wdata;
    logic         ram_we, ram_re;
    logic [31:0]  ram_rdata = '0;

    logic [31:0]  mem [64];

    int total = 0;
    int bad   = 0;

    logic         s_we    [NC+1];
    logic         s_re    [NC+1];
    logic         s_resp  [NC+1];
    logic         s_ready [NC+1];
    logic         s_cwv   [NC+1];
    logic [31:0]  s_cwd   [NC+1];
    logic [5:0]   s_addr  [NC+1];
    logic [31:0]  s_wdata [NC+1];
    logic [127:0] s_line  [NC+1];

    always #5 clk = ~clk;

    line_mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_read        (req_read),
        .req_write       (req_write),
        .rd_line_addr    (rd_line_addr),
        .wr_line_addr    (wr_line_addr),
        .wr_line_data    (wr_line_data),
        .crit_word       (crit_word),
        .resp_valid      (resp_valid),
        .resp_line_data  (resp_line_data),
        .crit_word_valid (crit_word_valid),
        .crit_word_data  (crit_word_data),
        .busy            (busy),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_we          (ram_we),
        .ram_re          (ram_re),
        .ram_rdata       (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic v, input logic rd, input logic wr,
                           input logic [3:0] rda, input logic [3:0] wra,
                           input logic [127:0] wd, input logic [1:0] cw);
        @(negedge clk);
        req_valid    = v;
        req_read     = rd;
        req_write    = wr;
        rd_line_addr = rda;
        wr_line_addr = wra;
        wr_line_data = wd;
        crit_word    = cw;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        for (int c = 1; c <= NC; c++) begin
            @(negedge clk);
            s_we[c]    = ram_we;
            s_re[c]    = ram_re;
            s_resp[c]  = resp_valid;
            s_ready[c] = req_ready;
            s_cwv[c]   = crit_word_valid;
            s_cwd[c]   = crit_word_data;
            s_addr[c]  = ram_addr;
            s_wdata[c] = ram_wdata;
            s_line[c]  = resp_line_data;
        end
    endtask

    typedef struct {
        logic         rd;
        logic         wr;
        logic [3:0]   rda;
        logic [3:0]   wra;
        logic [127:0] wdata;
        int           exp_resp;
        int           exp_re_first;
        logic [127:0] exp_line;
    } vec_t;

    vec_t vecs [6];

    localparam logic [127:0] L3 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L5 = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] L7 = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
    localparam logic [127:0] L1 = 128'h0BAD0003_0BAD0002_0BAD0001_0BAD0000;

    initial begin
        int first_resp, n_resp, n_busy, n_we, n_re, n_ovl, n_cwv, cwv_cyc;
        logic [127:0] line_at;
        logic [31:0]  cwd_at;
        logic [5:0]   exp_addr [4];
        logic [31:0]  wd;
        vec_t v;

        for (int i = 0; i < 64; i++) mem[i] = '0;

        vecs[0] = '{1'b0, 1'b1, 4'd0, 4'd3, L3, 5, 0, 128'h0};
        vecs[1] = '{1'b1, 1'b0, 4'd3, 4'd0, '0, 6, 1, L3};
        vecs[2] = '{1'b1, 1'b1, 4'd3, 4'd5, L5, 10, 5, L3};
        vecs[3] = '{1'b1, 1'b1, 4'd7, 4'd7, L7, 10, 5, L7};
        vecs[4] = '{1'b1, 1'b0, 4'd5, 4'd0, '0, 6, 1, L5};
        vecs[5] = '{1'b0, 1'b1, 4'd0, 4'd1, L1, 5, 0, L5};

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        rd_line_addr = '0;
        wr_line_addr = '0;
        wr_line_data = '0;
        crit_word    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp", resp_valid, 1'b0);
        chk("rst_we_re", {ram_we, ram_re}, 2'b00);
        chk("rst_addr", ram_addr, 6'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_line", resp_line_data, 128'd0);
        chk("rst_cw", {crit_word_valid, crit_word_data}, 33'd0);

        for (int t = 0; t < 6; t++) begin
            v = vecs[t];
            run_txn(1'b1, v.rd, v.wr, v.rda, v.wra, v.wdata, 2'd0);
            first_resp = 0; n_resp = 0; n_busy = 0;
            n_we = 0; n_re = 0; n_ovl = 0;
            line_at = '0;
            for (int c = 1; c <= NC; c++) begin
                if (s_resp[c]) begin
                    n_resp++;
                    if (first_resp == 0) begin
                        first_resp = c;
                        line_at = s_line[c];
                    end
                end
                if (!s_ready[c]) n_busy++;
                if (s_we[c]) n_we++;
                if (s_re[c]) n_re++;
                if (s_we[c] && s_re[c]) n_ovl++;
            end
            chk($sformatf("v%0d_resp_cyc", t), first_resp, v.exp_resp);
            chk($sformatf("v%0d_resp_cnt", t), n_resp, 1);
            chk($sformatf("v%0d_line", t), line_at, v.exp_line);
            chk($sformatf("v%0d_busy_cyc", t), n_busy, v.exp_resp);
            chk($sformatf("v%0d_we_cnt", t), n_we, v.wr ? 4 : 0);
            chk($sformatf("v%0d_re_cnt", t), n_re, v.rd ? 4 : 0);
            chk($sformatf("v%0d_overlap", t), n_ovl, 0);
            if (v.wr) begin
                for (int k = 0; k < 4; k++) begin
                    wd = v.wdata[k*32 +: 32];
                    chk($sformatf("v%0d_wb%0d", t, k),
                        {s_we[k+1], s_addr[k+1], s_wdata[k+1]},
                        {1'b1, v.wra, 2'(k), wd});
                end
            end
            if (v.rd) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("v%0d_rd%0d", t, k),
                        {s_re[v.exp_re_first+k], s_addr[v.exp_re_first+k]},
                        {1'b1, v.rda, 2'(k)});
                end
            end
        end

        // Reset during the second cycle of a refill.
        @(negedge clk);
        req_valid    = 1'b1;
        req_read     = 1'b1;
        rd_line_addr = 4'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_read = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_re", ram_re, 1'b0);
        chk("mid_rst_ready", req_ready, 1'b1);
        chk("mid_rst_line", resp_line_data, 128'd0);
        n_resp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (resp_valid) n_resp++;
        end
        chk("mid_rst_no_resp", n_resp, 0);

        // Request with neither flag set is dropped.
        run_txn(1'b1, 1'b0, 1'b0, 4'd3, 4'd3, L7, 2'd0);
        n_resp = 0; n_busy = 0; n_we = 0; n_re = 0;
        for (int c = 1; c <= NC; c++) begin
            if (s_resp[c]) n_resp++;
            if (!s_ready[c]) n_busy++;
            if (s_we[c]) n_we++;
            if (s_re[c]) n_re++;
        end
        chk("drop_resp", n_resp, 0);
        chk("drop_busy", n_busy, 0);
        chk("drop_ram", n_we + n_re, 0);

        // Refill of line 3 with crit_word=2.
`ifdef LINE_MEM_CRIT_WORD_FIRST_EN
        exp_addr = '{6'd14, 6'd15, 6'd12, 6'd13};
`else
        exp_addr = '{6'd12, 6'd13, 6'd14, 6'd15};
`endif
        run_txn(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, '0, 2'd2);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cw_rd%0d", k), {s_re[k+1], s_addr[k+1]},
                {1'b1, exp_addr[k]});
        end
        n_cwv = 0; cwv_cyc = 0; cwd_at = '0; first_resp = 0; line_at = '0;
        for (int c = 1; c <= NC; c++) begin
            if (s_cwv[c]) begin
                n_cwv++;
                if (cwv_cyc == 0) begin
                    cwv_cyc = c;
                    cwd_at = s_cwd[c];
                end
            end
            if (s_resp[c] && first_resp == 0) begin
                first_resp = c;
                line_at = s_line[c];
            end
        end
`ifdef LINE_MEM_CRIT_WORD_FIRST_EN
        chk("cw_cnt", n_cwv, 1);
        chk("cw_cyc", cwv_cyc, 2);
        chk("cw_data", cwd_at, 32'h33333333);
`else
        chk("cw_cnt", n_cwv, 0);
        chk("cw_data_zero", s_cwd[2], 32'h0);
`endif
        chk("cw_resp_cyc", first_resp, 6);
        chk("cw_line", line_at, L3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
